// File: rtl/enigma_tx_scheduler_if.sv
// Handshake bundle between the cipher source, the scheduler and uart_tx.
// The master drives data/flush and the uart_tx status; the slave (scheduler) drives the uart_tx request side.
interface enigma_tx_scheduler_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             i_Data_DV;
  logic [7:0]       i_Data_Byte;
  logic             i_Flush;
  logic             i_Tx_Active;
  logic             i_Tx_Done;
  logic             o_Tx_DV;
  logic [7:0]       o_Tx_Byte;
  logic [CNT_W-1:0] o_Fifo_Count;
  logic             o_Overflow;
  logic             o_Busy;

  modport master (
    output i_Data_DV, i_Data_Byte, i_Flush, i_Tx_Active, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte, o_Fifo_Count, o_Overflow, o_Busy
  );

  modport slave (
    input  i_Data_DV, i_Data_Byte, i_Flush, i_Tx_Active, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte, o_Fifo_Count, o_Overflow, o_Busy
  );
endinterface

// File: rtl/enigma_tx_scheduler.sv
// Buffers cipher bytes and feeds uart_tx one character per frame, inserting
// group spaces and line breaks lazily so no separator is ever trailing.
module enigma_tx_scheduler #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned GROUP_LEN       = 5,
  parameter int unsigned GROUPS_PER_LINE = 6
) (
  input logic                  i_Clk,
  input logic                  i_Rst,
  enigma_tx_scheduler_if.slave bus
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CHW   = $clog2(GROUP_LEN + 1);
  localparam int unsigned GRW   = $clog2(GROUPS_PER_LINE + 1);
  localparam logic [7:0]  CH_SP = 8'h20;
  localparam logic [7:0]  CH_CR = 8'h0D;
  localparam logic [7:0]  CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE, LETTER, SEP_SP, SEP_CR, SEP_LF, FL_CR, FL_LF, WAIT_DONE
  } state_t;

  state_t          state, state_d, ret, ret_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_d;
  logic [CHW-1:0]  char_cnt, char_cnt_d;
  logic [GRW-1:0]  group_cnt, group_cnt_d;
  logic            line_end, line_end_d;
  logic            sep_done, sep_done_d;
  logic            flush_pend, flush_pend_d;
  logic            tx_dv, tx_dv_d;
  logic [7:0]      tx_byte, tx_byte_d;
  logic            overflow, busy, busy_d;
  logic            full, empty, pop, push, drop;

  // FIFO bookkeeping; a pop in the same cycle frees the slot for a write to a full FIFO
  always_comb begin
    full  = (count == CW'(FIFO_DEPTH));
    empty = (count == '0);
    pop   = (state == LETTER);
    push  = bus.i_Data_DV && (!full || pop);
    drop  = bus.i_Data_DV && full && !pop;
    case ({push, pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr] <= bus.i_Data_Byte;
  end

  // Next-state, grouping counters and uart_tx request
  always_comb begin
    state_d      = state;
    ret_d        = ret;
    char_cnt_d   = char_cnt;
    group_cnt_d  = group_cnt;
    line_end_d   = line_end;
    sep_done_d   = sep_done;
    flush_pend_d = flush_pend;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte;

    case (state)
      IDLE: begin
        if (!bus.i_Tx_Active) begin
          if (!empty) begin
            if (!sep_done && (char_cnt == '0) && ((group_cnt != '0) || line_end))
              state_d = line_end ? SEP_CR : SEP_SP;
            else
              state_d = LETTER;
          end else if (flush_pend) begin
            if ((char_cnt != '0) || (group_cnt != '0) || line_end)
              state_d = FL_CR;
            else
              flush_pend_d = 1'b0;
          end
        end
      end
      LETTER: begin
        line_end_d = 1'b0;
        sep_done_d = 1'b0;
        if (char_cnt == CHW'(GROUP_LEN - 1)) begin
          char_cnt_d = '0;
          if (group_cnt == GRW'(GROUPS_PER_LINE - 1)) begin
            group_cnt_d = '0;
            line_end_d  = 1'b1;
          end else begin
            group_cnt_d = group_cnt + 1'b1;
          end
        end else begin
          char_cnt_d = char_cnt + 1'b1;
        end
        ret_d   = IDLE;
        state_d = WAIT_DONE;
      end
      SEP_SP: begin
        sep_done_d = 1'b1;
        ret_d      = IDLE;
        state_d    = WAIT_DONE;
      end
      SEP_CR: begin
        line_end_d = 1'b0;
        sep_done_d = 1'b1;
        ret_d      = SEP_LF;
        state_d    = WAIT_DONE;
      end
      SEP_LF: begin
        ret_d   = IDLE;
        state_d = WAIT_DONE;
      end
      FL_CR: begin
        ret_d   = FL_LF;
        state_d = WAIT_DONE;
      end
      FL_LF: begin
        char_cnt_d   = '0;
        group_cnt_d  = '0;
        line_end_d   = 1'b0;
        sep_done_d   = 1'b0;
        flush_pend_d = 1'b0;
        ret_d        = IDLE;
        state_d      = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i_Tx_Done) state_d = ret;
      end
      default: state_d = IDLE;
    endcase

    if (bus.i_Flush) flush_pend_d = 1'b1;

    // Emit states last exactly one cycle, so entering one is the start strobe
    case (state_d)
      LETTER:        begin tx_dv_d = 1'b1; tx_byte_d = mem[rd_ptr]; end
      SEP_SP:        begin tx_dv_d = 1'b1; tx_byte_d = CH_SP;       end
      SEP_CR, FL_CR: begin tx_dv_d = 1'b1; tx_byte_d = CH_CR;       end
      SEP_LF, FL_LF: begin tx_dv_d = 1'b1; tx_byte_d = CH_LF;       end
      default:       begin tx_dv_d = 1'b0;                          end
    endcase

    busy_d = (state_d != IDLE) || (count_d != '0) || flush_pend_d;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= IDLE;
      ret        <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      char_cnt   <= '0;
      group_cnt  <= '0;
      line_end   <= 1'b0;
      sep_done   <= 1'b0;
      flush_pend <= 1'b0;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'h00;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      ret        <= ret_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_d;
      char_cnt   <= char_cnt_d;
      group_cnt  <= group_cnt_d;
      line_end   <= line_end_d;
      sep_done   <= sep_done_d;
      flush_pend <= flush_pend_d;
      tx_dv      <= tx_dv_d;
      tx_byte    <= tx_byte_d;
      overflow   <= overflow | drop;
      busy       <= busy_d;
    end
  end

  assign bus.o_Tx_DV      = tx_dv;
  assign bus.o_Tx_Byte    = tx_byte;
  assign bus.o_Fifo_Count = count;
  assign bus.o_Overflow   = overflow;
  assign bus.o_Busy       = busy;
endmodule

// File: tb/tb_enigma_tx_scheduler.sv
// Directed bench for enigma_tx_scheduler with a behavioural uart_tx stand-in.
module tb_enigma_tx_scheduler;
  localparam int FRAME = 10;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  enigma_tx_scheduler_if #(.FIFO_DEPTH(8)) bus ();

  enigma_tx_scheduler #(
    .FIFO_DEPTH(8), .GROUP_LEN(5), .GROUPS_PER_LINE(6)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: a frame lasts FRAME cycles, Done pulses as Active drops
  int         frame_cnt = 0;
  int         dv_err = 0;
  int         hold_err = 0;
  bit         holding = 0;
  logic [7:0] cur_byte;
  logic [7:0] tx_log[$];
  int         tx_cyc[$];

  always @(negedge clk) begin
    if (bus.i_Tx_Done === 1'b1) bus.i_Tx_Done = 1'b0;
    if (rst === 1'b1) holding = 0;
    else if (holding && bus.o_Tx_Byte !== cur_byte) hold_err++;
    if (bus.o_Tx_DV === 1'b1) begin
      if (bus.i_Tx_Active === 1'b1 || frame_cnt != 0) dv_err++;
      tx_log.push_back(bus.o_Tx_Byte);
      tx_cyc.push_back(cyc);
      cur_byte = bus.o_Tx_Byte;
      holding = (rst !== 1'b1);
      frame_cnt = FRAME;
      bus.i_Tx_Active = 1'b1;
    end else if (frame_cnt != 0) begin
      frame_cnt--;
      if (frame_cnt == 0) begin
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done = 1'b1;
        holding = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic string q2s(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic put_byte(input logic [7:0] b);
    bus.i_Data_DV = 1'b1;
    bus.i_Data_Byte = b;
    @(posedge clk); #1;
    bus.i_Data_DV = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.i_Flush = 1'b1;
    @(posedge clk); #1;
    bus.i_Flush = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (bus.o_Busy === 1'b0 && frame_cnt == 0 && bus.i_Tx_Done === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    tx_log.delete();
    tx_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.o_Tx_DV !== 1'b0) $display("FAIL reset_tx_dv: got %b exp 0", bus.o_Tx_DV); else passed++;
    total++; if (bus.o_Tx_Byte !== 8'h00) $display("FAIL reset_tx_byte: got %h exp 00", bus.o_Tx_Byte); else passed++;
    total++; if (bus.o_Fifo_Count !== 4'd0) $display("FAIL reset_count: got %0d exp 0", bus.o_Fifo_Count); else passed++;
    total++; if (bus.o_Overflow !== 1'b0) $display("FAIL reset_overflow: got %b exp 0", bus.o_Overflow); else passed++;
    total++; if (bus.o_Busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", bus.o_Busy); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.o_Busy !== 1'b0) $display("FAIL reset_release_busy: got %b exp 0", bus.o_Busy); else passed++;
  endtask

  task automatic test_group();
    logic [7:0] expq[$];
    int t0;
    bit ok, bad;
    do_reset();
    expq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    t0 = cyc;
    put_byte(8'h41);
    total++; if (bus.o_Busy !== 1'b1) $display("FAIL group_busy_rise: got %b exp 1", bus.o_Busy); else passed++;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      put_byte(8'h41 + 8'(i));
    end
    wait_idle(ok);
    total++; if (!ok) $display("FAIL group_idle: got timeout exp idle"); else passed++;
    bad = (tx_log.size() != expq.size());
    if (!bad) foreach (expq[i]) if (tx_log[i] !== expq[i]) bad = 1;
    total++; if (bad) $display("FAIL group_stream: got %s exp %s", q2s(tx_log), q2s(expq)); else passed++;
    total++;
    if (tx_cyc.size() == 0 || tx_cyc[0] - t0 != 2)
      $display("FAIL group_latency: got %0d exp 2", (tx_cyc.size() == 0) ? -1 : tx_cyc[0] - t0);
    else passed++;
    total++; if (bus.o_Busy !== 1'b0) $display("FAIL group_busy_fall: got %b exp 0", bus.o_Busy); else passed++;
  endtask

  task automatic test_line_wrap();
    logic [7:0] expq[$];
    bit ok, bad, all_ok;
    do_reset();
    all_ok = 1;
    for (int i = 0; i < 31; i++) begin
      if (i != 0 && i % 5 == 0) begin
        if (i % 30 == 0) begin expq.push_back(8'h0D); expq.push_back(8'h0A); end
        else expq.push_back(8'h20);
      end
      expq.push_back(8'h41 + 8'(i % 26));
      put_byte(8'h41 + 8'(i % 26));
      wait_idle(ok);
      all_ok &= ok;
    end
    total++; if (!all_ok) $display("FAIL wrap_idle: got timeout exp idle"); else passed++;
    bad = (tx_log.size() != expq.size());
    if (!bad) foreach (expq[i]) if (tx_log[i] !== expq[i]) bad = 1;
    total++; if (bad) $display("FAIL wrap_stream: got %s exp %s", q2s(tx_log), q2s(expq)); else passed++;
    total++; if (bus.o_Overflow !== 1'b0) $display("FAIL wrap_overflow: got %b exp 0", bus.o_Overflow); else passed++;
  endtask

  task automatic test_flush();
    logic [7:0] expq[$];
    bit ok, bad;
    int n;
    do_reset();
    expq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46, 8'h47, 8'h0D, 8'h0A};
    for (int i = 0; i < 7; i++) begin
      put_byte(8'h41 + 8'(i));
      wait_idle(ok);
    end
    pulse_flush();
    total++; if (bus.o_Busy !== 1'b1) $display("FAIL flush_busy: got %b exp 1", bus.o_Busy); else passed++;
    wait_idle(ok);
    bad = !ok || (tx_log.size() != expq.size());
    if (!bad) foreach (expq[i]) if (tx_log[i] !== expq[i]) bad = 1;
    total++; if (bad) $display("FAIL flush_stream: got %s exp %s", q2s(tx_log), q2s(expq)); else passed++;
    n = tx_log.size();
    pulse_flush();
    wait_idle(ok);
    total++; if (!ok || tx_log.size() != n) $display("FAIL flush_empty_line: got %0d bytes exp %0d", tx_log.size(), n); else passed++;
    total++; if (bus.o_Busy !== 1'b0) $display("FAIL flush_pend_clear: got busy %b exp 0", bus.o_Busy); else passed++;
    // Flush arriving while letters are still buffered
    do_reset();
    expq = '{8'h58, 8'h59, 8'h5A, 8'h0D, 8'h0A};
    put_byte(8'h58); put_byte(8'h59); put_byte(8'h5A);
    pulse_flush();
    wait_idle(ok);
    bad = !ok || (tx_log.size() != expq.size());
    if (!bad) foreach (expq[i]) if (tx_log[i] !== expq[i]) bad = 1;
    total++; if (bad) $display("FAIL flush_drain_first: got %s exp %s", q2s(tx_log), q2s(expq)); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] expq[$];
    bit ok, bad;
    do_reset();
    expq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46, 8'h47, 8'h48, 8'h49};
    for (int i = 0; i < 10; i++) put_byte(8'h41 + 8'(i));
    total++; if (bus.o_Fifo_Count !== 4'd8) $display("FAIL burst_count: got %0d exp 8", bus.o_Fifo_Count); else passed++;
    total++; if (bus.o_Overflow !== 1'b1) $display("FAIL burst_overflow: got %b exp 1", bus.o_Overflow); else passed++;
    wait_idle(ok);
    bad = !ok || (tx_log.size() != expq.size());
    if (!bad) foreach (expq[i]) if (tx_log[i] !== expq[i]) bad = 1;
    total++; if (bad) $display("FAIL burst_stream: got %s exp %s", q2s(tx_log), q2s(expq)); else passed++;
    total++; if (bus.o_Overflow !== 1'b1) $display("FAIL burst_overflow_sticky: got %b exp 1", bus.o_Overflow); else passed++;
  endtask

  task automatic test_full_pop();
    logic [7:0] expq[$];
    bit ok, bad, seen;
    do_reset();
    expq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46, 8'h47, 8'h48, 8'h49, 8'h5A};
    for (int i = 0; i < 9; i++) put_byte(8'h41 + 8'(i));
    total++; if (bus.o_Fifo_Count !== 4'd8) $display("FAIL fullpop_prefill: got %0d exp 8", bus.o_Fifo_Count); else passed++;
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      if (bus.o_Tx_DV === 1'b1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    total++; if (!seen || bus.o_Tx_Byte !== 8'h42) $display("FAIL fullpop_letter: got %h exp 42", bus.o_Tx_Byte); else passed++;
    put_byte(8'h5A);
    total++; if (bus.o_Fifo_Count !== 4'd8) $display("FAIL fullpop_count: got %0d exp 8", bus.o_Fifo_Count); else passed++;
    total++; if (bus.o_Overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b exp 0", bus.o_Overflow); else passed++;
    wait_idle(ok);
    bad = !ok || (tx_log.size() != expq.size());
    if (!bad) foreach (expq[i]) if (tx_log[i] !== expq[i]) bad = 1;
    total++; if (bad) $display("FAIL fullpop_stream: got %s exp %s", q2s(tx_log), q2s(expq)); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] expq[$];
    bit ok, bad;
    do_reset();
    expq = '{8'h56, 8'h57, 8'h58, 8'h59, 8'h5A, 8'h51};
    for (int i = 0; i < 4; i++) begin
      put_byte(8'h56 + 8'(i));
      wait_idle(ok);
    end
    put_byte(8'h5A);
    for (int n = 0; n < 50 && tx_log.size() < 5; n++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (bus.o_Tx_DV !== 1'b0 || bus.o_Tx_Byte !== 8'h00 || bus.o_Fifo_Count !== 4'd0 ||
        bus.o_Overflow !== 1'b0 || bus.o_Busy !== 1'b0)
      $display("FAIL midreset_outputs: got dv=%b byte=%h cnt=%0d ovf=%b busy=%b exp 0 00 0 0 0",
               bus.o_Tx_DV, bus.o_Tx_Byte, bus.o_Fifo_Count, bus.o_Overflow, bus.o_Busy);
    else passed++;
    put_byte(8'h51);
    total++; if (tx_log.size() != 5) $display("FAIL midreset_hold_off: got %0d bytes exp 5", tx_log.size()); else passed++;
    wait_idle(ok);
    bad = !ok || (tx_log.size() != expq.size());
    if (!bad) foreach (expq[i]) if (tx_log[i] !== expq[i]) bad = 1;
    total++; if (bad) $display("FAIL midreset_stream: got %s exp %s", q2s(tx_log), q2s(expq)); else passed++;
  endtask

  task automatic test_protocol();
    total++; if (dv_err != 0) $display("FAIL dv_during_frame: got %0d exp 0", dv_err); else passed++;
    total++; if (hold_err != 0) $display("FAIL tx_byte_hold: got %0d exp 0", hold_err); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_Data_DV = 1'b0;
    bus.i_Data_Byte = 8'h00;
    bus.i_Flush = 1'b0;
    bus.i_Tx_Active = 1'b0;
    bus.i_Tx_Done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_group();
    test_line_wrap();
    test_flush();
    test_back_to_back();
    test_full_pop();
    test_reset_mid_frame();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/enigma_tx_scheduler.md
Name: enigma_tx_scheduler

Overview:
- Sequences the shared uart_tx transmitter for the cipher output stream.
- Buffers cipher bytes from the Enigma state machine, whose o_ready/o_outputData is a one-cycle strobe, in a small FIFO.
- Formats the output in classic Enigma groups: a space after every GROUP_LEN letters, and CR LF after GROUPS_PER_LINE groups.
- Sits between state_machine and uart_tx in enigma_top. Issues one i_Tx_DV strobe per character and waits for each frame to complete.

Parameters:
- FIFO_DEPTH, 8, cipher byte buffer depth; power of 2, minimum 2.
- GROUP_LEN, 5, letters per group.
- GROUPS_PER_LINE, 6, groups per line before CR LF.

Ports:
- i_Clk  in  1  system clock (25 MHz).
- i_Rst  in  1  synchronous, active-high reset.
- i_Data_DV  in  1  one-cycle strobe: i_Data_Byte is valid.
- i_Data_Byte  in  8  cipher byte from state_machine.
- i_Flush  in  1  one-cycle strobe: end the current line with CR LF.
- i_Tx_Active  in  1  uart_tx o_Tx_Active.
- i_Tx_Done  in  1  uart_tx o_Tx_Done (one-cycle pulse at end of frame).
- o_Tx_DV  out  1  one-cycle start strobe to uart_tx.
- o_Tx_Byte  out  8  byte to uart_tx; held stable from the o_Tx_DV cycle until i_Tx_Done.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_Overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- o_Busy  out  1  high when the FSM is not IDLE, or the FIFO is non-empty, or a flush is pending.

Behaviour:
- Reset:
  - o_Tx_DV=0, o_Tx_Byte=8'h00, o_Fifo_Count=0, o_Overflow=0, o_Busy=0.
  - FIFO pointers, char_cnt and group_cnt cleared; flush_pend=0; FSM to IDLE.
  - Reset mid-frame: the uart_tx frame already in progress finishes on its own. IDLE issues nothing while i_Tx_Active=1.
- FIFO write:
  - i_Data_DV with count<FIFO_DEPTH stores the byte.
  - i_Data_DV with count==FIFO_DEPTH drops the byte and sets o_Overflow until reset.
  - A write and a pop in the same cycle are both accepted; count is unchanged. When full, a same-cycle pop frees the slot and the write is accepted with no overflow.
- Counters:
  - char_cnt runs 0..GROUP_LEN-1.
  - group_cnt runs 0..GROUPS_PER_LINE-1.
- FSM states:
  - IDLE → SEP_SP / SEP_CR / LETTER / FL_CR, evaluated only when i_Tx_Active=0, with this priority:
    - (a) FIFO non-empty, char_cnt==0, group_cnt!=0 (the previous group completed): → SEP_SP. When group_cnt wrapped to 0 after a full line, the state is line_end=1, and the branch is SEP_CR instead.
    - (b) FIFO non-empty otherwise: → LETTER.
    - (c) FIFO empty, flush_pend=1: if char_cnt!=0, group_cnt!=0 or line_end=1, → FL_CR; else clear flush_pend and stay in IDLE.
  - Separators are emitted lazily, only when a following letter exists, so there is never a trailing space.
  - LETTER: o_Tx_Byte=FIFO head, o_Tx_DV=1 for one cycle, FIFO pop, line_end=0. char_cnt++; on wrap to 0, group_cnt++; on group_cnt wrap, line_end=1. → WAIT_DONE.
  - SEP_SP: o_Tx_Byte=8'h20, DV pulse → WAIT_DONE → IDLE. Next entry to IDLE goes to LETTER.
  - SEP_CR: o_Tx_Byte=8'h0D, DV pulse → WAIT_DONE → SEP_LF. line_end=0.
  - SEP_LF: o_Tx_Byte=8'h0A, DV pulse → WAIT_DONE → IDLE. A letter must follow, so IDLE takes branch (b).
  - FL_CR / FL_LF: same as SEP_CR / SEP_LF. After LF: char_cnt=0, group_cnt=0, line_end=0, flush_pend=0.
  - WAIT_DONE: hold o_Tx_Byte; on i_Tx_Done → return state.
- Flush:
  - i_Flush sets flush_pend in any state.
  - Buffered letters are always drained before the flush CR LF.
  - A second flush while one is pending is absorbed.
- Latency: i_Data_DV at cycle N with FIFO empty, FSM IDLE, i_Tx_Active=0 and no separator due → o_Tx_DV=1 at N+2.
- Exactly one o_Tx_DV per uart_tx frame. o_Tx_DV is never asserted while i_Tx_Active=1 or in WAIT_DONE.

Test Plan:
- Reset, then 5 bytes 'A'..'E' at 1-byte spacing → uart_tx sees "ABCDE" and no trailing space; first o_Tx_DV 2 cycles after the first i_Data_DV; o_Busy drops after the last i_Tx_Done.
- 31 letters with GROUP_LEN=5, GROUPS_PER_LINE=6 → 6 groups separated by 0x20; after the 30th letter, 0x0D 0x0A; then the 31st letter.
- 7 letters, then i_Flush → "ABCDE FG" 0x0D 0x0A; a second i_Flush on an empty line → no output, flush_pend clears.
- Burst of 10 i_Data_DV on consecutive cycles with FIFO_DEPTH=8 → 1 byte goes straight to uart_tx, 8 are buffered, 1 is dropped; o_Overflow=1 and sticky; 9 letters transmitted.
- Write on the same cycle as a LETTER pop with the FIFO full → no overflow; o_Fifo_Count stays 8.
- Assert i_Rst mid-frame with i_Tx_Active=1 → all outputs at reset values next cycle; no o_Tx_DV until i_Tx_Active=0; new data then resumes with char_cnt=0.
